// File: rtl/arm_dp_control_unit.sv
// rtl/arm_dp_control_unit.sv - fetch/decode/execute sequencer for ARM data-processing instructions
//
// Drives the control side of the RegisterFile / BarrelShifter / ARM_ALU datapath.
// Ports:
//   Clk, RESET      clock, asynchronous active-high reset
//   IR[31:0]        current instruction from the external IR register
//   FLAGS[3:0]      registered NZCV from the ALU ([3]=N [2]=Z [1]=C [0]=V)
//   MFC             memory function complete for the instruction fetch
//   MOV, LOAD_IR    fetch request and IR load strobe
//   OP, S, ALU_OUT  ALU opcode, flag-update enable, result drive enable
//   LOAD, LOADPC    RF (Rd) and PC write enables
//   IR_CU, RSLCT    register select source and the select fields themselves
//   ERR, STATE      sticky fetch-timeout error, current state for debug
`timescale 1ns/1ps

module arm_dp_control_unit #(
   parameter int MFC_TIMEOUT = 15
) (
   input  logic        Clk,
   input  logic        RESET,
   input  logic [31:0] IR,
   input  logic [3:0]  FLAGS,
   input  logic        MFC,
   output logic        MOV,
   output logic        LOAD_IR,
   output logic [4:0]  OP,
   output logic        S,
   output logic        ALU_OUT,
   output logic        LOAD,
   output logic        LOADPC,
   output logic        IR_CU,
   output logic [19:0] RSLCT,
   output logic        ERR,
   output logic [2:0]  STATE
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_LATCH  = 3'd2,
      S_PCINC  = 3'd3,
      S_DECODE = 3'd4,
      S_EXEC   = 3'd5,
      S_ABORT  = 3'd7
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       cond_pass;
   logic       flag_n, flag_z, flag_c, flag_v;
   logic       wr_rd;

   // IR[25] (immediate select) and IR[7:4] (shift fields) belong to the shifter, not to us.
   logic unused_ir;
   assign unused_ir = ^{IR[25], IR[7:4]};

   assign flag_n = FLAGS[3];
   assign flag_z = FLAGS[2];
   assign flag_c = FLAGS[1];
   assign flag_v = FLAGS[0];

   always_comb begin
      cond_pass = 1'b0;
      case (IR[31:28])
         4'h0:    cond_pass = flag_z;
         4'h1:    cond_pass = !flag_z;
         4'h2:    cond_pass = flag_c;
         4'h3:    cond_pass = !flag_c;
         4'h4:    cond_pass = flag_n;
         4'h5:    cond_pass = !flag_n;
         4'h6:    cond_pass = flag_v;
         4'h7:    cond_pass = !flag_v;
         4'h8:    cond_pass = flag_c && !flag_z;
         4'h9:    cond_pass = !flag_c || flag_z;
         4'hA:    cond_pass = (flag_n == flag_v);
         4'hB:    cond_pass = (flag_n != flag_v);
         4'hC:    cond_pass = !flag_z && (flag_n == flag_v);
         4'hD:    cond_pass = flag_z || (flag_n != flag_v);
         4'hE:    cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   // Compare-class opcodes (TST/TEQ/CMP/CMN, 8..11) only update flags.
   assign wr_rd = (IR[24:23] != 2'b10);

   always_comb begin
      state_d = state_q;
      cnt_d   = 4'd0;
      case (state_q)
         S_IDLE:  state_d = S_FETCH;
         S_FETCH: begin
            if (MFC) begin
               state_d = S_LATCH;
            end else if (cnt_q == 4'(MFC_TIMEOUT - 1)) begin
               // This is the MFC_TIMEOUT-th consecutive low sample.
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_LATCH:  state_d = S_PCINC;
         S_PCINC:  state_d = S_DECODE;
         S_DECODE: begin
            if (IR[27:26] != 2'b00) state_d = S_FETCH;
            else if (cond_pass)     state_d = S_EXEC;
            else                    state_d = S_FETCH;
         end
         S_EXEC:  state_d = S_FETCH;
         S_ABORT: state_d = S_ABORT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge Clk or posedge RESET) begin
      if (RESET) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs follow the state combinationally so RESET drops them without waiting for a clock.
   always_comb begin
      MOV     = 1'b0;
      LOAD_IR = 1'b0;
      OP      = 5'd0;
      S       = 1'b0;
      ALU_OUT = 1'b0;
      LOAD    = 1'b0;
      LOADPC  = 1'b0;
      IR_CU   = 1'b0;
      RSLCT   = 20'd0;
      case (state_q)
         S_FETCH: MOV     = 1'b1;
         S_LATCH: LOAD_IR = 1'b1;
         S_PCINC: begin
            OP      = 5'd17;
            ALU_OUT = 1'b1;
            LOADPC  = 1'b1;
            RSLCT   = 20'hFF00F;
         end
         S_EXEC: begin
            OP      = {1'b0, IR[24:21]};
            S       = IR[20];
            ALU_OUT = 1'b1;
            IR_CU   = 1'b1;
            RSLCT   = {IR[19:16], IR[15:12], IR[11:8], IR[3:0], IR[19:16]};
            LOAD    = wr_rd;
            LOADPC  = wr_rd && (IR[15:12] == 4'hF);
         end
         default: ;
      endcase
   end

   assign ERR   = (state_q == S_ABORT);
   assign STATE = state_q;

endmodule

// File: doc/arm_dp_control_unit.md
# arm_dp_control_unit

Control sequencer that drives the RegisterFile / BarrelShifter / ARM_ALU datapath for ARM data-processing instructions. It is the initiator side of the datapath control interface: it produces the OP, S, ALU_OUT, LOAD, LOADPC, IR_CU and RSLCT signals that the datapath consumes. It runs a fetch / PC-increment / decode / execute loop with a memory-complete handshake and condition-code evaluation. It sits between the instruction memory interface and the prefab ALU+RF+BS datapath.

## Interface
- MFC_TIMEOUT, 15: max cycles FETCH waits for MFC before ABORT (4-bit counter, 1..15)
- Clk  in  1  clock; state updates on rising edge
- RESET  in  1  asynchronous, active-high reset
- IR  in  32  current instruction (external IR register, loaded by LOAD_IR)
- FLAGS  in  4  registered NZCV from ALU: [3]=N [2]=Z [1]=C [0]=V
- MFC  in  1  memory function complete (fetch data valid)
- MOV  out  1  memory operation valid (fetch request, PC as address)
- LOAD_IR  out  1  load external IR from memory data
- OP  out  5  ALU opcode
- S  out  1  ALU flag-update enable
- ALU_OUT  out  1  ALU result drive enable onto RF input bus
- LOAD  out  1  RF write enable (Rd = RSLCT[15:12])
- LOADPC  out  1  PC (R15) write enable
- IR_CU  out  1  1 = register selects from IR fields, 0 = CU-forced selects
- RSLCT  out  20  [3:0] Rn, [7:4] Rm, [11:8] Rs, [15:12] Rd, [19:16] Rn copy
- ERR  out  1  sticky fetch-timeout error
- STATE  out  3  current state (debug)

## Operation
- States: IDLE=0, FETCH=1, LATCH=2, PCINC=3, DECODE=4, EXEC=5, ABORT=7.
- Outputs are decoded combinationally from state and IR. All outputs not listed for a state are 0, and RSLCT=0.
- IDLE: entered on RESET. Goes to FETCH on the next edge.
- FETCH: MOV=1. If MFC=1, go to LATCH and clear the counter. Otherwise increment the wait counter. When the counter reaches MFC_TIMEOUT with MFC still 0, go to ABORT.
- LATCH: LOAD_IR=1. Go to PCINC.
- PCINC: OP=17 (A+4), ALU_OUT=1, LOADPC=1, S=0, IR_CU=0, RSLCT Rn=Rd=4'hF. Go to DECODE.
- DECODE: all control outputs 0.
  - If IR[27:26]!=2'b00 (not data-processing), go to FETCH as a NOP.
  - Otherwise evaluate cond=IR[31:28]. Pass goes to EXEC; fail goes to FETCH.
- Condition table:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
  - AL 1, 1111 never.
- EXEC: OP={1'b0,IR[24:21]}, S=IR[20], ALU_OUT=1, IR_CU=1.
  - RSLCT = {IR[19:16], IR[15:12], IR[11:8], IR[3:0], IR[19:16]}.
  - LOAD=1 unless IR[24:21] is 8..11 (TST/TEQ/CMP/CMN).
  - If LOAD and Rd=15, LOADPC=1 as well.
  - Go to FETCH.
- ABORT: ERR=1, all other controls 0. Held until RESET.
- OP 16 (pass B) is reserved and is never issued by this block.

## Timing
- RESET asserted: asynchronously forces state=IDLE, counter=0 and ERR=0. All outputs read 0 during reset, including MOV.
- Minimum instruction latency with MFC high on the first FETCH cycle: 5 cycles (FETCH, LATCH, PCINC, DECODE, EXEC). A failed-condition instruction or a NOP takes 4 cycles.
- MFC is sampled only in FETCH and ignored in every other state.
- With N wait cycles (MFC low), FETCH lasts N+1 cycles. ABORT is entered on the edge after MFC_TIMEOUT consecutive low samples.
- DECODE samples FLAGS at the end of its cycle. Flags written in EXEC of instruction k are therefore visible to instruction k+1.
- RESET asserted mid-instruction: an EXEC write in progress is dropped, because LOAD and LOADPC go to 0 immediately.

## Test plan
- Reset, then MFC=1 always, IR=32'hE0810002 (ADD R0,R1,R2): STATE sequence 0,1,2,3,4,5,1. EXEC drives OP=4, S=0, LOAD=1, RSLCT=20'h1_0_0_2_1. PCINC drives OP=17, LOADPC=1, RSLCT Rn=Rd=F.
- IR=32'h01510002 (CMPEQ R1,R2, S=1) with FLAGS=4'b0100: EXEC drives OP=10, S=1, LOAD=0. With FLAGS=4'b0000, DECODE goes straight to FETCH and no EXEC occurs.
- IR=32'hE1A0F001 (MOV PC,R1): EXEC drives LOAD=1 and LOADPC=1. IR=32'hE5900000 (LDR): NOP, no EXEC.
- MFC held low 3 cycles then high: FETCH occupies 4 cycles, ERR stays 0. MFC held low 15 cycles: STATE=7 and ERR=1 held. RESET then clears ERR and returns STATE=0.
- RESET asserted asynchronously mid-EXEC (between edges): LOAD, ALU_OUT and STATE are 0 before the next Clk edge.
